// File: rtl/controlador_ula_if.sv
// Bundle between the two requesters, the shared ALU datapath and controlador_ula.
// master: requester/datapath side; slave: the controller.
interface controlador_ula_if;
    logic       req0;
    logic       req1;
    logic [2:0] op0;
    logic [2:0] op1;
    logic [7:0] a0;
    logic [7:0] b0;
    logic [7:0] a1;
    logic [7:0] b1;
    logic       ack0;
    logic       ack1;
    logic [7:0] resultado;
    logic [2:0] flags;
    logic       origem;
    logic       ocupado;
    logic [2:0] alu_op;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [7:0] alu_resultado;
    logic [2:0] alu_flags;

    modport master (
        output req0, req1, op0, op1, a0, b0, a1, b1,
        output alu_resultado, alu_flags,
        input  ack0, ack1, resultado, flags, origem, ocupado,
        input  alu_op, alu_a, alu_b
    );

    modport slave (
        input  req0, req1, op0, op1, a0, b0, a1, b1,
        input  alu_resultado, alu_flags,
        output ack0, ack1, resultado, flags, origem, ocupado,
        output alu_op, alu_a, alu_b
    );
endinterface

// File: rtl/controlador_ula.sv
// Round-robin sequencer sharing one 8-bit ALU + flag generator between two requesters.
// Ports: clk, reset (sync, active-high), bus (controlador_ula_if.slave).
module controlador_ula (
    input logic             clk,
    input logic             reset,
    controlador_ula_if.slave bus
);
    typedef enum logic [1:0] {
        OCIOSO  = 2'd0,
        EXECUTA = 2'd1,
        CAPTURA = 2'd2
    } estado_t;

    estado_t    estado_q, estado_d;
    logic       ultimo_q, ultimo_d;
    logic       idx_q, idx_d;
    logic [7:0] res_q, res_d;
    logic [2:0] flg_q, flg_d;
    logic       org_q, org_d;
    logic [2:0] op_q, op_d;
    logic [7:0] a_q, a_d;
    logic [7:0] b_q, b_d;
    logic       venc;

    // Requester 1 wins when alone, or on a tie when 0 was served last.
    assign venc = bus.req1 & (~bus.req0 | ~ultimo_q);

    always_comb begin
        estado_d = estado_q;
        ultimo_d = ultimo_q;
        idx_d    = idx_q;
        res_d    = res_q;
        flg_d    = flg_q;
        org_d    = org_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        case (estado_q)
            OCIOSO: begin
                if (bus.req0 | bus.req1) begin
                    idx_d    = venc;
                    ultimo_d = venc;
                    op_d     = venc ? bus.op1 : bus.op0;
                    a_d      = venc ? bus.a1  : bus.a0;
                    b_d      = venc ? bus.b1  : bus.b0;
                    estado_d = EXECUTA;
                end
            end
            EXECUTA: begin
                res_d    = bus.alu_resultado;
                flg_d    = bus.alu_flags;
                org_d    = idx_q;
                estado_d = CAPTURA;
            end
            CAPTURA: estado_d = OCIOSO;
            default: estado_d = OCIOSO;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            estado_q <= OCIOSO;
            ultimo_q <= 1'b1;
            idx_q    <= 1'b0;
            res_q    <= 8'h00;
            flg_q    <= 3'b000;
            org_q    <= 1'b0;
            op_q     <= 3'b000;
            a_q      <= 8'h00;
            b_q      <= 8'h00;
        end else begin
            estado_q <= estado_d;
            ultimo_q <= ultimo_d;
            idx_q    <= idx_d;
            res_q    <= res_d;
            flg_q    <= flg_d;
            org_q    <= org_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
        end
    end

    // In CAPTURA origem already holds the granted index.
    assign bus.ack0      = (estado_q == CAPTURA) & ~org_q;
    assign bus.ack1      = (estado_q == CAPTURA) &  org_q;
    assign bus.ocupado   = (estado_q != OCIOSO);
    assign bus.resultado = res_q;
    assign bus.flags     = flg_q;
    assign bus.origem    = org_q;
    assign bus.alu_op    = op_q;
    assign bus.alu_a     = a_q;
    assign bus.alu_b     = b_q;
endmodule

// File: doc/controlador_ula.md
# controlador_ula

Round-robin sequencer that shares the single 8-bit ALU and its flag generator between two requesters. Each requester presents an operation code and two operands. The controller grants one requester, drives the ALU, and registers the 8-bit result and the {Overflow, Carry, Zero} flags. It then returns them to the granted requester with a one-cycle acknowledge. It sits between the operand-entry/control logic and the combinational ALU + flag-generator datapath.

## Interface
- No parameters: data width fixed at 8, operation code 3 bits, flags 3 bits, 2 requesters.
- clk  in  1  single system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high; one clock and reset is synchronous and active-high.
- req0, req1  in  1 each  request level; held high until the matching ack.
- op0, op1  in  3 each  operation code (100 = ADD, 101 = SUB; others passed through unchanged).
- a0, b0, a1, b1  in  8 each  operands; must be stable while the matching req is high.
- ack0, ack1  out  1 each  one-cycle completion pulse to the granted requester.
- resultado  out  8  registered result of the last completed operation.
- flags  out  3  registered {Overflow, Carry, Zero} of the last completed operation.
- origem  out  1  index of the requester whose result is on resultado/flags.
- ocupado  out  1  high whenever the state is not OCIOSO.
- alu_op  out  3  operation code driven to the ALU and flag generator.
- alu_a, alu_b  out  8 each  operands driven to the ALU.
- alu_resultado  in  8  combinational ALU result; settles within the cycle alu_* are applied.
- alu_flags  in  3  combinational flag-generator output {Overflow, Carry, Zero}.

## Operation
- FSM states:
  - OCIOSO: wait for a request.
  - EXECUTA: alu_* driven from the latched operands.
  - CAPTURA: result and flags already registered; ack asserted.
- OCIOSO:
  - If any req is high, the arbiter picks the winner.
  - The winner's op/a/b are latched into alu_op/alu_a/alu_b, and the winner index is latched.
  - Next state is EXECUTA. With no request, stay in OCIOSO.
- Arbitration:
  - A single request wins outright.
  - If both are high, the requester not served last wins.
  - The "ultimo" pointer updates at grant.
  - Reset value of ultimo = 1, so requester 0 wins the first tie.
- EXECUTA: at the clock edge, alu_resultado → resultado, alu_flags → flags, latched index → origem; next state CAPTURA.
- CAPTURA:
  - ack of the granted requester is high for exactly this cycle; the other ack stays low.
  - Next state is always OCIOSO.
- resultado/flags/origem hold their value until the next capture; they do not change in OCIOSO.
- alu_op/alu_a/alu_b hold their last latched value outside EXECUTA and are not cleared at completion.
- Requesters drop req in the cycle after they see ack. A req still high in the OCIOSO cycle after ack is a new request.
- Operand changes while req is high and not yet granted are honoured, since the sample is taken at grant. Changes after grant are ignored.
- The controller adds no arithmetic: results and flags are exactly alu_resultado/alu_flags as sampled at the end of EXECUTA.

## Timing
- Reset (synchronous, checked every edge, overrides all states) sets:
  - state = OCIOSO, ultimo = 1;
  - ack0 = ack1 = 0, ocupado = 0;
  - resultado = 8'h00, flags = 3'b000, origem = 0;
  - alu_op = 3'b000, alu_a = alu_b = 8'h00.
- Reset in EXECUTA or CAPTURA aborts the operation. No ack is issued for it, and the request must be re-presented.
- Latency for a req seen high in OCIOSO cycle n:
  - EXECUTA in cycle n+1;
  - ack plus valid resultado/flags in cycle n+2;
  - OCIOSO in cycle n+3.
- Throughput: one operation per 3 cycles. With both requesters continuously pending, grants alternate 0,1,0,1…
- ocupado = 1 in cycles n+1 and n+2.
- All outputs are registered or state-decoded; no combinational path from req/op/a/b to any output.
- alu_resultado/alu_flags must meet setup within one cycle of alu_* changing.

## Test plan
- Reset then idle: assert reset 2 cycles, release, no req → all outputs 0, ocupado 0, no ack for 10 cycles.
- Single ADD: req0, op0=100, a0=8'h7F, b0=8'h01 → ack0 at cycle n+2 with resultado=8'h80, flags=3'b100 (Overflow), origem=0; ack1 never.
- SUB zero and carry gating: req1, op1=101, a1=b1=8'h55 → resultado=8'h00, flags=3'b001; then ADD 8'hFF+8'h01 on req1 → resultado=8'h00, flags=3'b011.
- Simultaneous requests: req0 and req1 high from reset release, each dropped after its ack → grants 0 then 1, ack0 at n+2, ack1 at n+5; then both re-requested → grant 0.
- Reset mid-operation: reset asserted in EXECUTA → no ack, resultado keeps 8'h00, state OCIOSO; the re-presented request completes normally.
- Held request: req0 kept high after ack0 → second grant in the following OCIOSO cycle, ack0 again 3 cycles later; req1 arriving meanwhile wins the next tie.
